// File: rtl/sum_frame_accum.sv
// sum_frame_accum
// Accumulates N consecutive DW-bit unsigned samples into an AW-bit frame total.
// Each total is presented with an overflow flag on a valid/ready output port.
// Optional build macro SUM_FRAME_ACCUM_SATURATE_EN: when it is defined, the
// accumulator clamps to all-ones once it carries out. When it is not defined,
// the accumulator wraps modulo 2^AW. In both builds o_ovf flags the carry.
module sum_frame_accum #(
    parameter  int unsigned DW = 8,
    parameter  int unsigned N  = 4,
    parameter  int unsigned AW = 12,
    localparam int unsigned CW = $clog2(N)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_srst,
    input  logic [DW-1:0] i_data,
    input  logic          i_valid,
    output logic          o_ready,
    output logic [AW-1:0] o_sum,
    output logic          o_ovf,
    output logic          o_valid,
    input  logic          i_ready
);

    typedef enum logic {
        ACC  = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [AW-1:0] acc;
    logic [CW-1:0] cnt;
    logic          ovf_q;

    logic          in_hs;
    logic          out_hs;
    logic          last;
    logic [AW:0]   data_ext;
    logic [AW:0]   sum_ext;
    logic          carry;
    logic [AW-1:0] acc_nxt;

    assign in_hs    = i_valid && o_ready;
    assign out_hs   = o_valid && i_ready;
    assign last     = (cnt == CW'(N - 1));
    assign data_ext = {{(AW + 1 - DW){1'b0}}, i_data};
    assign sum_ext  = {1'b0, acc} + data_ext;
    assign carry    = sum_ext[AW];

`ifdef SUM_FRAME_ACCUM_SATURATE_EN
    // Once clamped, every later add either stays at all-ones or carries again.
    // The clamp therefore holds for the rest of the frame without extra state.
    assign acc_nxt = carry ? {AW{1'b1}} : sum_ext[AW-1:0];
`else
    assign acc_nxt = sum_ext[AW-1:0];
`endif

    // State register: the only FSM storage.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        // NOTE: clocked state uses non-blocking assignments so every register
        // samples pre-edge values, independent of block ordering.
        if (!i_rst_n) begin
            state <= ACC;
        end else if (i_srst) begin
            state <= ACC;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: close the frame on the N-th accept and release on the output handshake.
    always_comb begin
        // NOTE: default assignment first so no path leaves state_nxt unassigned
        // (which would infer a latch).
        state_nxt = state;
        unique case (state)
            ACC:     if (in_hs && last) state_nxt = HOLD;
            HOLD:    if (out_hs)        state_nxt = ACC;
            default:                    state_nxt = ACC;
        endcase
    end

    // Output decode: the handshake flags depend only on the registered state.
    always_comb begin
        o_ready = 1'b0;
        o_valid = 1'b0;
        unique case (state)
            ACC:     o_ready = 1'b1;
            HOLD:    o_valid = 1'b1;
            default: o_ready = 1'b1;
        endcase
    end

    // Datapath: accumulate accepted samples and capture the total when the frame closes.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            acc   <= '0;
            cnt   <= '0;
            ovf_q <= 1'b0;
            o_sum <= '0;
            o_ovf <= 1'b0;
        end else if (i_srst) begin
            acc   <= '0;
            cnt   <= '0;
            ovf_q <= 1'b0;
            o_sum <= '0;
            o_ovf <= 1'b0;
        end else if (in_hs) begin
            if (last) begin
                o_sum <= acc_nxt;
                o_ovf <= ovf_q | carry;
                acc   <= '0;
                cnt   <= '0;
                ovf_q <= 1'b0;
            end else begin
                acc   <= acc_nxt;
                cnt   <= cnt + CW'(1);
                ovf_q <= ovf_q | carry;
            end
        end
    end

endmodule

// File: doc/sum_frame_accum.md
# sum_frame_accum

Downstream consumer of the adder stage's 8-bit result `o_c`. It accepts one sum per valid/ready handshake and accumulates `N` consecutive sums into a wider frame total. It then presents that total with an overflow flag on a valid/ready output port. It is the first clocked stage after the purely combinational force-port/invert/add path and gives the datapath a registered, back-pressurable boundary.

## Interface
Parameters:
- `DW`, 8, input sample width; matches the adder output width.
- `N`, 4, samples per frame; legal range 2..256.
- `AW`, 12, accumulator and output width; must satisfy `AW > DW`.
- `CW`, `$clog2(N)`, frame counter width; derived, not overridden.

Ports:
- `i_clk`  in  1  sole clock; all state updates on its rising edge.
- `i_rst_n`  in  1  asynchronous, active-low reset.
- `i_srst`  in  1  synchronous clear, active-high.
- `i_data`  in  DW  sample; unsigned; driven from the adder stage `o_c`.
- `i_valid`  in  1  `i_data` is valid this cycle.
- `o_ready`  out  1  block accepts a sample this cycle.
- `o_sum`  out  AW  frame total.
- `o_ovf`  out  1  frame total exceeded `2^AW-1`; valid while `o_valid` is high.
- `o_valid`  out  1  `o_sum` and `o_ovf` are valid.
- `i_ready`  in  1  downstream accepts the result.

## Operation
- State machine has two states:
  - `ACC`: `o_ready`=1, `o_valid`=0.
  - `HOLD`: `o_ready`=0, `o_valid`=1.
- An input handshake occurs when `i_valid && o_ready`. An output handshake occurs when `o_valid && i_ready`.
- In `ACC`, each input handshake does the following:
  - Zero-extends `i_data` and computes `acc + i_data` at width AW+1.
  - Increments `cnt`.
  - Sets sticky `ovf_q` if bit AW of that sum is 1.
- On the handshake where `cnt == N-1`:
  - Registers the final total into `o_sum`.
  - Registers `ovf_q | carry` into `o_ovf`.
  - Clears `acc`, `cnt` and `ovf_q`.
  - Moves to `HOLD`.
- In `HOLD`, `i_data` and `i_valid` are ignored. `o_sum` and `o_ovf` hold stable until the output handshake. On that handshake the block returns to `ACC`.
- `i_valid` without `o_ready` has no effect. Upstream must hold its data.
- `i_srst`=1 has priority over every handshake in the same cycle. It forces `ACC` and clears `acc`, `cnt`, `ovf_q`, `o_sum`, `o_ovf` and `o_valid`. A frame in progress or a result pending in `HOLD` is discarded.
- `i_rst_n` low clears the same state asynchronously, at any point in a frame.
- Reset values: `o_ready`=1, `o_valid`=0, `o_sum`=0, `o_ovf`=0, internal `acc`=0, `cnt`=0, state=`ACC`.
- Counter wrap: `cnt` never reaches `N`; it returns to 0 on the closing handshake.

## Timing
- `o_valid` rises on the cycle after the N-th input handshake.
- `o_ready` is a registered function of state, with no combinational path from `i_ready` or `i_valid`.
- The same cycle that completes the output handshake cannot also accept input. `o_ready` returns high one cycle after that handshake.
- Peak throughput is one frame per N+1 cycles when `i_ready` is held at 1.
- `o_sum` and `o_ovf` change only on the transition into `HOLD`, on `i_srst`, or on reset.
- Deasserting `i_rst_n` is synchronised externally. The first accept can occur on the first rising edge after release.

## Configuration
- Macro `SUM_FRAME_ACCUM_SATURATE_EN`.
- Defined: once the carry-out (bit AW) is set, `acc` clamps to `2^AW-1` and stays there for the rest of the frame. `o_sum` = `{AW{1'b1}}` and `o_ovf`=1.
- Undefined: arithmetic wraps modulo `2^AW`. `o_sum` = true total mod `2^AW`, and `o_ovf`=1 still flags the wrap.
- Only the clamp logic differs. Interface, state machine and timing are identical in both builds.

## Test plan
- Reset, then feed 4 back-to-back samples 0x01, 0x02, 0x03, 0x04 with `i_ready`=1 (default parameters):
  - `o_valid`=1 one cycle after the 4th accept, with `o_sum`=10 and `o_ovf`=0.
  - `o_ready` is low for exactly 1 cycle.
- Feed 4 samples of 0xFF with `i_ready`=0 for 5 cycles:
  - `o_sum`=1020 and `o_valid` stay stable, and `o_ready` stays 0.
  - Driving `i_valid`=1 with 0x55 during this hold changes nothing.
  - After `i_ready`=1, the next frame starts from 0.
- Set `AW`=9 and feed 4 samples of 200:
  - With the macro defined: `o_sum`=511, `o_ovf`=1.
  - Without the macro: `o_sum`=288, `o_ovf`=1.
- Pulse `i_srst` after 2 of 4 samples (0x10, 0x20), then feed 4 samples of 0x01:
  - No result is produced for the aborted frame.
  - The next result is `o_sum`=4.
- Assert `i_rst_n`=0 asynchronously in mid-cycle while in `HOLD`:
  - `o_valid`, `o_sum` and `o_ovf` go to 0 immediately, without waiting for a clock edge.
  - `o_ready`=1 after release.
- Random `i_valid`/`i_ready` stimulus over 1000 frames:
  - Scoreboard sums of accepted samples match `o_sum`.
  - No sample is accepted while `o_valid`=1.
